// File: rtl/nes_attr_row_fetch.sv
// Attribute-row fetch stage: walks one 32-tile background row,
// reads one attribute byte per 4-tile group, streams 2-bit palettes.
module nes_attr_row_fetch #(
  parameter int ROM_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] row_i,
  input  logic       nt_sel_i,
  output logic       busy,
  output logic [6:0] attr_addr,
  input  logic [7:0] attr_dout,
  output logic [1:0] pal_o,
  output logic [4:0] col_o,
  output logic [4:0] row_o,
  output logic       pal_valid,
  input  logic       pal_ready,
  output logic       last
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT
  } state_t;

  // Value of the fetch-cycle counter on the cycle that captures ROM data.
  localparam logic FC_LAST = (ROM_LAT != 0);

  state_t     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic       nt_q, nt_d;
  logic [2:0] g_q, g_d;
  logic [1:0] t_q, t_d;
  logic [1:0] t_n;
  logic       fc_q, fc_d;
  logic [7:0] attr_reg_q, attr_reg_d;
  logic       busy_q, busy_d;
  logic [6:0] addr_q, addr_d;
  logic [1:0] pal_q, pal_d;
  logic [4:0] col_q, col_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;

  // Quadrant select inside one attribute byte: {bottom, right}.
  function automatic logic [1:0] quad_pal(
    input logic [7:0] b,
    input logic       q_bot,
    input logic       q_right
  );
    logic [1:0] p;
    unique case ({q_bot, q_right})
      2'b00:   p = b[1:0];
      2'b01:   p = b[3:2];
      2'b10:   p = b[5:4];
      default: p = b[7:6];
    endcase
    return p;
  endfunction

  // Next-state and next-output computation for the row walker.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    nt_d       = nt_q;
    g_d        = g_q;
    t_d        = t_q;
    t_n        = t_q + 2'd1;
    fc_d       = fc_q;
    attr_reg_d = attr_reg_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    pal_d      = pal_q;
    col_d      = col_q;
    valid_d    = valid_q;
    last_d     = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = row_i;
          nt_d    = nt_sel_i;
          g_d     = 3'd0;
          t_d     = 2'd0;
          fc_d    = 1'b0;
          busy_d  = 1'b1;
          addr_d  = {nt_sel_i, row_i[4:2], 3'd0};
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (fc_q == FC_LAST) begin
          attr_reg_d = attr_dout;
          t_d        = 2'd0;
          valid_d    = 1'b1;
          col_d      = {g_q, 2'd0};
          pal_d      = quad_pal(attr_dout, row_q[1], 1'b0);
          last_d     = 1'b0;
          state_d    = EMIT;
        end else begin
          fc_d = 1'b1;
        end
      end
      EMIT: begin
        if (pal_ready) begin
          if (t_q != 2'd3) begin
            t_d    = t_n;
            col_d  = {g_q, t_n};
            pal_d  = quad_pal(attr_reg_q, row_q[1], t_n[1]);
            last_d = (g_q == 3'd7) && (t_n == 2'd3);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (g_q != 3'd7) begin
              g_d     = g_q + 3'd1;
              fc_d    = 1'b0;
              addr_d  = {nt_q, row_q[4:2], g_q + 3'd1};
              state_d = FETCH;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any row in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= 5'd0;
      nt_q       <= 1'b0;
      g_q        <= 3'd0;
      t_q        <= 2'd0;
      fc_q       <= 1'b0;
      attr_reg_q <= 8'd0;
      busy_q     <= 1'b0;
      addr_q     <= 7'd0;
      pal_q      <= 2'd0;
      col_q      <= 5'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      nt_q       <= nt_d;
      g_q        <= g_d;
      t_q        <= t_d;
      fc_q       <= fc_d;
      attr_reg_q <= attr_reg_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      pal_q      <= pal_d;
      col_q      <= col_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign busy      = busy_q;
  assign attr_addr = addr_q;
  assign pal_o     = pal_q;
  assign col_o     = col_q;
  assign row_o     = row_q;
  assign pal_valid = valid_q;
  assign last      = last_q;

endmodule

// File: tb/tb_nes_attr_row_fetch.sv
// Bench for nes_attr_row_fetch: two instances (ROM_LAT 0 and 1),
// scoreboard queues filled by stimulus, drained by a beat monitor.
module tb_nes_attr_row_fetch;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
    logic [1:0] pal;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s [2];
  logic [4:0] row_s [2];
  logic       nt_s [2];
  logic       ready_s [2];
  logic       busy_w [2];
  logic [6:0] addr_w [2];
  logic [1:0] pal_w [2];
  logic [4:0] col_w [2];
  logic [4:0] rowo_w [2];
  logic       valid_w [2];
  logic       last_w [2];
  logic [7:0] dout0;
  logic [7:0] dout1;
  logic [7:0] rom [128];

  beat_t exp_q0 [$];
  beat_t exp_q1 [$];
  int    ncomp = 0;
  int    nfail = 0;
  int    nbeats [2];
  logic [1:0] got_pal [2][32];

  always #5 clk = ~clk;

  assign dout0 = rom[addr_w[0]];
  always @(posedge clk) dout1 <= rom[addr_w[1]];

  nes_attr_row_fetch #(.ROM_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .row_i(row_s[0]), .nt_sel_i(nt_s[0]), .busy(busy_w[0]),
    .attr_addr(addr_w[0]), .attr_dout(dout0), .pal_o(pal_w[0]),
    .col_o(col_w[0]), .row_o(rowo_w[0]), .pal_valid(valid_w[0]),
    .pal_ready(ready_s[0]), .last(last_w[0])
  );

  nes_attr_row_fetch #(.ROM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .row_i(row_s[1]), .nt_sel_i(nt_s[1]), .busy(busy_w[1]),
    .attr_addr(addr_w[1]), .attr_dout(dout1), .pal_o(pal_w[1]),
    .col_o(col_w[1]), .row_o(rowo_w[1]), .pal_valid(valid_w[1]),
    .pal_ready(ready_s[1]), .last(last_w[1])
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    ncomp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_pal(input logic nt,
                                         input logic [4:0] row,
                                         input logic [4:0] col);
    logic [7:0] b;
    int q;
    b = rom[{nt, row[4:2], col[4:2]}];
    q = 2 * int'({row[1], col[1]});
    return b[q +: 2];
  endfunction

  task automatic push(input int d, input logic nt,
                      input logic [4:0] row, input int ncol);
    beat_t e;
    for (int c = 0; c < ncol; c++) begin
      e.row  = row;
      e.col  = 5'(c);
      e.pal  = exp_pal(nt, row, 5'(c));
      e.last = (c == 31);
      if (d == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per transfer, checks stall holds.
  initial begin
    beat_t e;
    beat_t cur;
    logic  prev_stall [2];
    beat_t prev [2];
    bit    empty;
    prev_stall = '{1'b0, 1'b0};
    prev = '{13'd0, 13'd0};
    nbeats = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cur.row  = rowo_w[d];
        cur.col  = col_w[d];
        cur.pal  = pal_w[d];
        cur.last = last_w[d];
        if (rst_n === 1'b1 && valid_w[d] === 1'b1) begin
          if (prev_stall[d]) check("hold", 32'(cur), 32'(prev[d]));
          if (ready_s[d]) begin
            empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
              ncomp++;
              nfail++;
              $display("FAIL extra_beat: dut %0d col %0d not expected",
                       d, cur.col);
            end else begin
              if (d == 0) e = exp_q0.pop_front();
              else e = exp_q1.pop_front();
              check("beat", 32'(cur), 32'(e));
              got_pal[d][cur.col] = cur.pal;
              nbeats[d]++;
            end
          end
        end
        prev_stall[d] = (rst_n === 1'b1) && (valid_w[d] === 1'b1)
                        && !ready_s[d];
        prev[d] = cur;
      end
    end
  end

  task automatic run_row(input int d, input logic nt, input logic [4:0] row,
                         input int stall_col, input bit mid_start,
                         input int abort_col);
    int nb0, cyc, busy_cyc, fetch_cyc, first_v, grp, stalls, nexp;
    logic prev_fetch;
    logic [6:0] base;
    bit aborted;
    nexp = (abort_col >= 0) ? abort_col : 32;
    push(d, nt, row, nexp);
    nb0 = nbeats[d];
    base = {nt, row[4:2], 3'd0};
    start_s[d] = 1'b1;
    row_s[d] = row;
    nt_s[d] = nt;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    check("busy_on", 32'(busy_w[d]), 32'd1);
    check("addr_first", 32'(addr_w[d]), 32'(base));
    busy_cyc = 0; fetch_cyc = 0; first_v = 0; grp = -1;
    stalls = 0; cyc = 1; prev_fetch = 1'b0; aborted = 1'b0;
    while (busy_w[d] && cyc < 200) begin
      busy_cyc++;
      if (!valid_w[d]) begin
        fetch_cyc++;
        if (!prev_fetch) grp++;
        check("addr", 32'(addr_w[d]), 32'(base + 7'(grp)));
      end
      prev_fetch = !valid_w[d];
      if (valid_w[d] && first_v == 0) first_v = cyc;
      start_s[d] = mid_start && (cyc == 12);
      row_s[d] = mid_start && (cyc == 12) ? ~row : row;
      if (abort_col >= 0 && valid_w[d] && col_w[d] == 5'(abort_col)) begin
        ready_s[d] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end else if (stall_col >= 0 && valid_w[d] &&
                   col_w[d] == 5'(stall_col) && stalls < 3) begin
        ready_s[d] = 1'b0;
        stalls++;
      end else begin
        ready_s[d] = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ready_s[d] = 1'b1;
    start_s[d] = 1'b0;
    row_s[d] = row;
    if (aborted) begin
      check("rst_out", 32'({busy_w[d], valid_w[d], last_w[d], pal_w[d],
                            col_w[d], rowo_w[d], addr_w[d]}), 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check("rst_idle", 32'({busy_w[d], valid_w[d]}), 32'd0);
      end
    end else begin
      check("busy_cycles", 32'(busy_cyc),
            32'(8 * (5 + d) + ((stall_col >= 0) ? 3 : 0)));
      check("fetch_cycles", 32'(fetch_cyc), 32'(8 * (1 + d)));
      check("first_valid", 32'(first_v), 32'(2 + d));
      check("groups", 32'(grp), 32'd7);
      @(posedge clk); #1;
      check("no_restart", 32'(busy_w[d]), 32'd0);
    end
    check("beat_count", 32'(nbeats[d] - nb0), 32'(nexp));
    check("queue_empty",
          32'((d == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    rom[0] = 8'hAA; rom[1] = 8'hAA; rom[2] = 8'hEA; rom[3] = 8'hE4;
    for (int i = 4; i < 8; i++) rom[i] = 8'h1B;
    rom[8] = 8'h00;
    for (int i = 9; i < 16; i++) rom[i] = 8'h55;
    rom[7'h49] = 8'h88;
    rom[7'h4A] = 8'hAA;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; row_s[d] = 5'd0; nt_s[d] = 1'b0; ready_s[d] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int d = 0; d < 2; d++)
      check("reset_state", 32'({busy_w[d], valid_w[d], last_w[d], pal_w[d],
                                col_w[d], rowo_w[d], addr_w[d]}), 32'd0);

    run_row(0, 1'b0, 5'd0, -1, 1'b0, -1);
    check("r0_c0", 32'(got_pal[0][0]), 32'd2);
    check("r0_c7", 32'(got_pal[0][7]), 32'd2);
    check("r0_c8", 32'(got_pal[0][8]), 32'd2);
    check("r0_c10", 32'(got_pal[0][10]), 32'd2);

    run_row(0, 1'b0, 5'd2, -1, 1'b0, -1);
    check("r2_c8", 32'(got_pal[0][8]), 32'd2);
    check("r2_c10", 32'(got_pal[0][10]), 32'd3);
    check("r2_c0", 32'(got_pal[0][0]), 32'd2);

    run_row(0, 1'b0, 5'd4, -1, 1'b0, -1);
    check("r4_c0", 32'(got_pal[0][0]), 32'd0);
    check("r4_c3", 32'(got_pal[0][3]), 32'd0);
    check("r4_c4", 32'(got_pal[0][4]), 32'd1);
    check("r4_c31", 32'(got_pal[0][31]), 32'd1);

    run_row(0, 1'b1, 5'd4, -1, 1'b0, -1);
    check("n1_c4", 32'(got_pal[0][4]), 32'd0);
    check("n1_c5", 32'(got_pal[0][5]), 32'd0);
    check("n1_c6", 32'(got_pal[0][6]), 32'd2);
    check("n1_c7", 32'(got_pal[0][7]), 32'd2);
    check("n1_c8", 32'(got_pal[0][8]), 32'd2);
    check("n1_c11", 32'(got_pal[0][11]), 32'd2);
    check("n1_c12", 32'(got_pal[0][12]), 32'd0);

    run_row(1, 1'b0, 5'd0, 5, 1'b1, -1);
    check("lat1_c5", 32'(got_pal[1][5]), 32'd2);
    check("lat1_c10", 32'(got_pal[1][10]), 32'd2);

    run_row(0, 1'b0, 5'd2, -1, 1'b0, 13);
    run_row(0, 1'b1, 5'd4, -1, 1'b0, -1);
    check("clean_c6", 32'(got_pal[0][6]), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
